// File: rtl/online_pkg.sv
`default_nettype none
// ============================================================================
// Module      : online_pkg
// Description : Shared types and helpers for the radix-2^k online blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package online_pkg;

    // Width of one signed digit for a radix of 2^log2r.
    function automatic int dw(input int log2r);
        return log2r + 1;
    endfunction

    localparam int C_LOG2R_DEF = 2;

    // Signed digit for the default radix-4 configuration.
    typedef logic signed [C_LOG2R_DEF:0] digit_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Digit-set bound must satisfy ceil((r+1)/2) <= a <= r-1.
    function automatic bit a_legal(input int log2r, input int a);
        int r;
        r = 1 << log2r;
        return (a >= (r + 2) / 2) && (a <= r - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/online_tw_r2k.sv
`default_nettype none
// ============================================================================
// Module      : online_tw_r2k
// Description : Combinational transfer/interim split p -> (t, w), |w| <= A-1.
// Revision    : 1.0 - initial release
// ============================================================================
module online_tw_r2k
    import online_pkg::*;
#(
    parameter int LOG2R = 2,
    parameter int A     = 3
) (
    input  logic signed [LOG2R+2:0] p,
    output logic signed [1:0]       t,
    output logic signed [LOG2R+2:0] w
);

    localparam int c_pw = LOG2R + 3;
    localparam logic signed [c_pw-1:0] c_r = c_pw'(1 << LOG2R);
    localparam logic signed [c_pw-1:0] c_a = c_pw'(A);

    always_comb begin
        t = 2'sb00;
        w = p;
        if (p >= c_a) begin
            t = 2'sb01;
            w = p - c_r;
        end else if (p <= -c_a) begin
            t = 2'sb11;
            w = p + c_r;
        end
    end

endmodule
`default_nettype wire

// File: rtl/online_addsub_r2k.sv
`default_nettype none
// ============================================================================
// Module      : online_addsub_r2k
// Description : Radix-2^LOG2R online (MSD-first) adder/subtractor, delay 1.
// Revision    : 1.0 - initial release
// ============================================================================
module online_addsub_r2k
    import online_pkg::*;
#(
    parameter int LOG2R = 2,
    parameter int A     = 3,
    parameter int MAXN  = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_first,
    input  logic                             in_last,
    input  logic                             sub,
    input  logic signed [dw(LOG2R)-1:0]      xi,
    input  logic signed [dw(LOG2R)-1:0]      yi,
    output logic                             out_valid,
    output logic                             out_first,
    output logic                             out_last,
    output logic signed [dw(LOG2R)-1:0]      zo,
    output logic [$clog2(MAXN+2)-1:0]        out_idx,
    output logic                             err
);

    localparam int c_dw = dw(LOG2R);
    localparam int c_pw = LOG2R + 3;
    localparam int c_iw = $clog2(MAXN + 2);
    localparam logic [c_iw-1:0]        c_maxn = c_iw'(MAXN);
    localparam logic signed [c_pw-1:0] c_a    = c_pw'(A);

    generate
        if (!a_legal(LOG2R, A)) begin : g_bad_a
            $fatal(1, "online_addsub_r2k: digit bound A illegal for this radix");
        end
    endgenerate

    state_t                   r_state, w_state_nxt;
    logic signed [c_pw-1:0]   r_w, w_w_nxt;
    logic                     r_mode, w_mode_nxt;
    logic [c_iw-1:0]          r_cnt, w_cnt_nxt;
    logic                     r_ov, r_of, r_ol, r_err;
    logic                     w_ov_nxt, w_of_nxt, w_ol_nxt, w_err_nxt;
    logic signed [c_dw-1:0]   r_zo, w_zo_nxt;
    logic [c_iw-1:0]          r_idx, w_idx_nxt;

    logic                     w_accept;
    logic                     w_mode_sub;
    logic                     w_range_err;
    logic                     w_hit_max;
    logic [c_iw-1:0]          w_cnt_inc;
    logic signed [c_pw-1:0]   w_x, w_y, w_p, w_w, w_t_ext;
    logic signed [1:0]        w_t;

    assign in_ready   = (r_state != S_FLUSH);
    assign w_accept   = in_valid && in_ready;
    assign w_x        = {{2{xi[c_dw-1]}}, xi};
    assign w_y        = {{2{yi[c_dw-1]}}, yi};
    // A new operation uses its own sub bit; later digits use the latched mode.
    assign w_mode_sub = in_first ? sub : r_mode;
    assign w_p        = w_mode_sub ? (w_x - w_y) : (w_x + w_y);
    assign w_range_err = (w_x > c_a) || (w_x < -c_a) || (w_y > c_a) || (w_y < -c_a);
    assign w_cnt_inc  = in_first ? c_iw'(1) : (r_cnt + c_iw'(1));
    assign w_hit_max  = (w_cnt_inc == c_maxn);
    assign w_t_ext    = {{(c_pw-2){w_t[1]}}, w_t};

    online_tw_r2k #(
        .LOG2R (LOG2R),
        .A     (A)
    ) u_tw (
        .p (w_p),
        .t (w_t),
        .w (w_w)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_w_nxt     = r_w;
        w_mode_nxt  = r_mode;
        w_cnt_nxt   = r_cnt;
        w_ov_nxt    = 1'b0;
        w_of_nxt    = 1'b0;
        w_ol_nxt    = 1'b0;
        w_zo_nxt    = '0;
        w_idx_nxt   = '0;
        w_err_nxt   = w_accept && w_range_err;
        case (r_state)
            S_IDLE, S_RUN: begin
                if (w_accept) begin
                    if (in_first || (r_state == S_RUN)) begin
                        w_ov_nxt    = 1'b1;
                        w_w_nxt     = w_w;
                        w_cnt_nxt   = w_cnt_inc;
                        w_state_nxt = (in_last || w_hit_max) ? S_FLUSH : S_RUN;
                        if (!in_last && w_hit_max) begin
                            w_err_nxt = 1'b1;
                        end
                        if (in_first) begin
                            // z_0 is the first transfer; an open operation is abandoned.
                            w_mode_nxt = sub;
                            w_of_nxt   = 1'b1;
                            w_zo_nxt   = c_dw'(w_t_ext);
                            if (r_state == S_RUN) begin
                                w_err_nxt = 1'b1;
                            end
                        end else begin
                            w_zo_nxt  = c_dw'(r_w + w_t_ext);
                            w_idx_nxt = r_cnt;
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                w_ov_nxt    = 1'b1;
                w_ol_nxt    = 1'b1;
                w_zo_nxt    = c_dw'(r_w);
                w_idx_nxt   = r_cnt;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_w     <= '0;
            r_mode  <= 1'b0;
            r_cnt   <= '0;
            r_ov    <= 1'b0;
            r_of    <= 1'b0;
            r_ol    <= 1'b0;
            r_zo    <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_w     <= w_w_nxt;
            r_mode  <= w_mode_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ov    <= w_ov_nxt;
            r_of    <= w_of_nxt;
            r_ol    <= w_ol_nxt;
            r_zo    <= w_zo_nxt;
            r_idx   <= w_idx_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign out_valid = r_ov;
    assign out_first = r_of;
    assign out_last  = r_ol;
    assign zo        = r_zo;
    assign out_idx   = r_idx;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_online_addsub_r2k.sv
`default_nettype none
// ============================================================================
// Module      : tb_online_addsub_r2k
// Description : Scoreboard bench for the radix-4 and radix-8 online adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_online_addsub_r2k;
    import online_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // Radix-4, A=3 instance
    logic a_in_valid, a_in_ready, a_in_first, a_in_last, a_sub;
    digit_t a_xi, a_yi, a_zo;
    logic a_out_valid, a_out_first, a_out_last, a_err;
    logic [6:0] a_out_idx;

    // Radix-8, A=5 instance
    logic b_in_valid, b_in_ready, b_in_first, b_in_last, b_sub;
    logic signed [3:0] b_xi, b_yi, b_zo;
    logic b_out_valid, b_out_first, b_out_last, b_err;
    logic [6:0] b_out_idx;

    online_addsub_r2k #(.LOG2R(2), .A(3), .MAXN(64)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_first(a_in_first), .in_last(a_in_last), .sub(a_sub), .xi(a_xi), .yi(a_yi),
        .out_valid(a_out_valid), .out_first(a_out_first), .out_last(a_out_last),
        .zo(a_zo), .out_idx(a_out_idx), .err(a_err)
    );

    online_addsub_r2k #(.LOG2R(3), .A(5), .MAXN(64)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_first(b_in_first), .in_last(b_in_last), .sub(b_sub), .xi(b_xi), .yi(b_yi),
        .out_valid(b_out_valid), .out_first(b_out_first), .out_last(b_out_last),
        .zo(b_zo), .out_idx(b_out_idx), .err(b_err)
    );

    typedef struct {
        int d;
        int idx;
        bit first;
        bit last;
        int cyc;
    } exp_t;

    exp_t   qa[$];
    longint qb[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    int     acc_cyc = 0;
    int     last_stalls = 0;
    int     a_err_seen = 0;
    int     b_err_seen = 0;
    exp_t   mon_e;
    longint b_acc = 0;
    longint b_exp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Radix-4 monitor: every presented digit must match the head of the queue.
    always @(negedge clk) begin
        if (a_err) a_err_seen++;
        if (a_out_valid) begin
            n_checks++;
            if (qa.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_out: got zo=%0d idx=%0d first=%0b last=%0b, expected no output",
                         a_zo, a_out_idx, a_out_first, a_out_last);
            end else begin
                mon_e = qa.pop_front();
                if (int'(a_zo) != mon_e.d || int'(a_out_idx) != mon_e.idx || a_out_first != mon_e.first
                    || a_out_last != mon_e.last || cyc != mon_e.cyc) begin
                    n_errors++;
                    $display("FAIL out_digit: got zo=%0d idx=%0d first=%0b last=%0b cyc=%0d, expected zo=%0d idx=%0d first=%0b last=%0b cyc=%0d",
                             a_zo, a_out_idx, a_out_first, a_out_last, cyc,
                             mon_e.d, mon_e.idx, mon_e.first, mon_e.last, mon_e.cyc);
                end
            end
        end
    end

    // Radix-8 monitor: digit bound on every digit, exact value at out_last.
    always @(negedge clk) begin
        if (b_err) b_err_seen++;
        if (b_out_valid) begin
            n_checks++;
            if (b_zo > 5 || b_zo < -5) begin
                n_errors++;
                $display("FAIL r8_bound: got zo=%0d, expected |zo| <= 5", b_zo);
            end
            b_acc = b_out_first ? longint'(b_zo) : (b_acc * 8 + longint'(b_zo));
            if (b_out_last) begin
                n_checks++;
                if (qb.size() == 0) begin
                    n_errors++;
                    $display("FAIL r8_value: got value %0d, expected no result", b_acc);
                end else begin
                    b_exp = qb.pop_front();
                    if (b_acc != b_exp) begin
                        n_errors++;
                        $display("FAIL r8_value: got %0d, expected %0d", b_acc, b_exp);
                    end
                end
            end
        end
    end

    task automatic push(input int d, input int idx, input bit f, input bit l, input int c);
        exp_t e;
        e.d = d; e.idx = idx; e.first = f; e.last = l; e.cyc = c;
        qa.push_back(e);
    endtask

    // Presents a digit pair and holds it until in_ready shows it will be taken.
    task automatic drive_a(input bit f, input bit l, input bit s, input int x, input int y);
        int waits;
        waits = 0;
        @(negedge clk);
        a_in_valid = 1'b1; a_in_first = f; a_in_last = l; a_sub = s;
        a_xi = 3'(x); a_yi = 3'(y);
        while (!a_in_ready && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        n_checks++;
        if (!a_in_ready) begin
            n_errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, expected 1", waits);
        end
        last_stalls = waits;
        acc_cyc = cyc + 1;
    endtask

    task automatic idle_a(input int n);
        repeat (n) begin
            @(negedge clk);
            a_in_valid = 1'b0; a_in_first = 1'b0; a_in_last = 1'b0;
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic chk_rst(input string name);
        n_checks++;
        if (a_out_valid !== 1'b0 || a_out_first !== 1'b0 || a_out_last !== 1'b0 || a_zo !== 3'd0
            || a_out_idx !== 7'd0 || a_err !== 1'b0 || a_in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s: got valid=%0b first=%0b last=%0b zo=%0d idx=%0d err=%0b ready=%0b, expected all 0 and ready=1",
                     name, a_out_valid, a_out_first, a_out_last, a_zo, a_out_idx, a_err, a_in_ready);
        end
    endtask

    initial begin : wd
        #100000;
        $display("FAIL watchdog: got no finish by 100000, expected earlier finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        int x, y;
        longint xv, yv;
        reset = 1'b0;
        a_in_valid = 0; a_in_first = 0; a_in_last = 0; a_sub = 0; a_xi = '0; a_yi = '0;
        b_in_valid = 0; b_in_first = 0; b_in_last = 0; b_sub = 0; b_xi = '0; b_yi = '0;
        #1 reset = 1'b1;
        #2 chk_rst("reset_state");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // add 0.33 + 0.33 (radix 4) -> 1, 3, 2
        drive_a(1, 0, 0, 3, 3);  push(1, 0, 1, 0, acc_cyc);
        drive_a(0, 1, 0, 3, 3);  push(3, 1, 0, 0, acc_cyc); push(2, 2, 0, 1, acc_cyc + 1);
        idle_a(1);

        // sub [2,-1] - [-1,2] -> 1, -2, 1; sub ignored on the second digit
        drive_a(1, 0, 1, 2, -1); push(1, 0, 1, 0, acc_cyc);
        drive_a(0, 1, 0, -1, 2); push(-2, 1, 0, 0, acc_cyc); push(1, 2, 0, 1, acc_cyc + 1);
        idle_a(1);
        check("flush_ready_low", int'(a_in_ready), 0);
        idle_a(1);
        check("ready_after_flush", int'(a_in_ready), 1);

        // bubbles between digits
        drive_a(1, 0, 0, 3, 3);  push(1, 0, 1, 0, acc_cyc);
        idle_a(2);
        drive_a(0, 1, 0, 3, 3);  push(3, 1, 0, 0, acc_cyc); push(2, 2, 0, 1, acc_cyc + 1);
        idle_a(2);

        // back-to-back: single-digit add then two-digit sub
        drive_a(1, 1, 0, 1, 1);  push(0, 0, 1, 0, acc_cyc); push(2, 1, 0, 1, acc_cyc + 1);
        drive_a(1, 0, 1, 0, 0);  push(0, 0, 1, 0, acc_cyc);
        check("b2b_stall", last_stalls, 1);
        drive_a(0, 1, 0, 3, -3); push(1, 1, 0, 0, acc_cyc); push(2, 2, 0, 1, acc_cyc + 1);
        idle_a(3);
        check("no_err_clean", a_err_seen, 0);

        // reset mid-operation
        drive_a(1, 0, 0, 3, 3);  push(1, 0, 1, 0, acc_cyc);
        drive_a(0, 0, 0, 3, 3);  push(3, 1, 0, 0, acc_cyc);
        @(negedge clk);
        a_in_valid = 1'b0;
        #1 reset = 1'b1;
        #1 chk_rst("reset_mid_run");
        @(negedge clk);
        reset = 1'b0;
        idle_a(2);
        check("queue_after_reset", qa.size(), 0);
        drive_a(1, 0, 1, 2, -1); push(1, 0, 1, 0, acc_cyc);
        drive_a(0, 1, 1, -1, 2); push(-2, 1, 0, 0, acc_cyc); push(1, 2, 0, 1, acc_cyc + 1);
        idle_a(3);

        // in_first while running aborts the old operation
        e0 = a_err_seen;
        drive_a(1, 0, 0, 3, 3);  push(1, 0, 1, 0, acc_cyc);
        drive_a(1, 0, 0, 1, 1);  push(0, 0, 1, 0, acc_cyc);
        drive_a(0, 1, 0, 1, 1);  push(2, 1, 0, 0, acc_cyc); push(2, 2, 0, 1, acc_cyc + 1);
        idle_a(3);
        check("err_first_in_run", a_err_seen - e0, 1);

        // out-of-range digit -4 with A=3
        e0 = a_err_seen;
        drive_a(1, 1, 0, -4, 0); push(-1, 0, 1, 0, acc_cyc); push(0, 1, 0, 1, acc_cyc + 1);
        idle_a(3);
        check("err_range", a_err_seen - e0, 1);

        // non-first digit in IDLE is dropped
        e0 = a_err_seen;
        drive_a(0, 1, 0, 1, 1);
        idle_a(3);
        check("err_idle_drop", a_err_seen - e0, 1);

        // radix-8, A=5: 16-digit random operands, value must be exact
        for (int op = 0; op < 4; op++) begin
            xv = 0; yv = 0;
            for (int j = 1; j <= 16; j++) begin
                x = int'($urandom_range(10)) - 5;
                y = int'($urandom_range(10)) - 5;
                xv = xv * 8 + longint'(x);
                yv = yv * 8 + longint'(y);
                @(negedge clk);
                b_in_valid = 1'b1; b_in_first = (j == 1); b_in_last = (j == 16);
                b_sub = op[0]; b_xi = 4'(x); b_yi = 4'(y);
            end
            qb.push_back(op[0] ? (xv - yv) : (xv + yv));
            repeat (3) begin
                @(negedge clk);
                b_in_valid = 1'b0; b_in_first = 1'b0; b_in_last = 1'b0;
            end
        end
        check("r8_no_err", b_err_seen, 0);
        check("queue_a_empty", qa.size(), 0);
        check("queue_b_empty", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
